// File: rtl/libalu.sv
// Shared ALU/muldiv encodings and types for the EX-stage arithmetic units.
package libalu;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  // RV32M funct3 encodings for the divide group.
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic c);
    return c ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, try the subtract, keep or restore.
module div_step
  import libalu::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_next_o,
  output logic [XLEN-1:0] quo_next_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = shifted - {1'b0, div_i};
    // A borrow out of bit XLEN means the divisor did not fit; keep the shifted value.
    if (!diff[XLEN]) begin
      rem_next_o = diff[XLEN-1:0];
      quo_next_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_next_o = shifted[XLEN-1:0];
      quo_next_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// Handshake: div_en_i is a level held for the whole operation (low aborts); div_finish_o pulses one cycle with the result valid.
module divider_iter
  import libalu::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            div_en_i,
  input  logic [2:0]      funct3_32,
  input  logic [XLEN-1:0] muldiv_a_i,
  input  logic [XLEN-1:0] muldiv_b_i,
  output logic            div_finish_o,
  output logic            div_busy_o,
  output logic [XLEN-1:0] muldiv_result_o
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;

  logic             op_signed, op_rem;
  logic [XLEN-1:0]  step_rem, step_quo;

  div_step u_step (
    .rem_i      (rem_q),
    .quo_i      (quo_q),
    .div_i      (dvs_q),
    .rem_next_o (step_rem),
    .quo_next_o (step_quo)
  );

  always_comb begin
    op_signed = (funct3_32 == F3_DIV) || (funct3_32 == F3_REM);
    op_rem    = (funct3_32 == F3_REM) || (funct3_32 == F3_REMU);

    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    is_rem_d = is_rem_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;

    case (state_q)
      IDLE: begin
        if (div_en_i) begin
          is_rem_d = op_rem;
          sign_a_d = op_signed & muldiv_a_i[XLEN-1];
          sign_b_d = op_signed & muldiv_b_i[XLEN-1];
          rem_d    = '0;
          quo_d    = neg_if(muldiv_a_i, sign_a_d);
          dvs_d    = neg_if(muldiv_b_i, sign_b_d);
          cnt_d    = CNT_W'(XLEN - 1);
          if (muldiv_b_i == '0) begin
            result_d = op_rem ? muldiv_a_i : '1;
            state_d  = DONE;
          end else if (op_signed && (muldiv_a_i == 32'h8000_0000) && (muldiv_b_i == '1)) begin
            result_d = op_rem ? '0 : 32'h8000_0000;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!div_en_i) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            result_d = is_rem_q ? neg_if(step_rem, sign_a_q)
                                : neg_if(step_quo, sign_a_q ^ sign_b_q);
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      is_rem_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      is_rem_q <= is_rem_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  assign div_finish_o    = (state_q == DONE);
  assign div_busy_o      = (state_q != IDLE);
  assign muldiv_result_o = result_q;

endmodule
